// File: rtl/elevator_display_pkg.sv
// Shared definitions for the elevator status display: active-high {g..a} segment
// codes, the direction type and the floor-digit lookup.
package elevator_display_pkg;

    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_UP    = 7'b0100011;
    localparam logic [6:0] SEG_DOWN  = 7'b0011100;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;

    function automatic logic [6:0] seg_digit(input logic [1:0] floor);
        case (floor)
            2'd1:    return SEG_1;
            2'd2:    return SEG_2;
            2'd3:    return SEG_3;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Free-running half-period counter producing the emergency blink phase; the phase
// toggles each time the counter wraps after CLK_FREQ/(2*BLINK_HZ) cycles.
module blink_tick_gen #(
    parameter int CLK_FREQ = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic phase_o
);

    localparam int HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (cnt_q == CW'(HALF - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/elevator_status_display.sv
// Decodes elevator floor/status lines into a floor digit (hex0) and a symbol digit (hex1)
// with travel direction and encoding-error flags. Define ELEV_CHIME_EN for the arrival chime.
module elevator_status_display
    import elevator_display_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int BLINK_HZ       = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int CHIME_MS       = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       floor1,
    input  logic       floor2,
    input  logic       floor3,
    input  logic       door,
    input  logic       moving,
    input  logic       sos_mode,
    input  logic       weight_limit_exceeded,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       dir_up,
    output logic       dir_down,
`ifdef ELEV_CHIME_EN
    output logic       chime,
`endif
    output logic       status_err
);

    localparam logic [6:0] POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    if (BLINK_HZ < 1 || BLINK_HZ > CLK_FREQ / 2 || CHIME_MS < 1) begin : g_param_check
        $error("elevator_status_display: parameter out of range");
    end

    // S1: register all inputs once
    logic [2:0] floor_s1_q;
    logic       door_s1_q, moving_s1_q, sos_s1_q, wt_s1_q;

    always_ff @(posedge clk) begin
        floor_s1_q  <= {floor3, floor2, floor1};
        door_s1_q   <= door;
        moving_s1_q <= moving;
        sos_s1_q    <= sos_mode;
        wt_s1_q     <= weight_limit_exceeded;
    end

    logic phase;

    blink_tick_gen #(
        .CLK_FREQ(CLK_FREQ),
        .BLINK_HZ(BLINK_HZ)
    ) u_blink (
        .clk    (clk),
        .rst_n  (rst_n),
        .phase_o(phase)
    );

    logic       valid, between;
    logic [1:0] cur, last_floor_q, last_floor_d;
    dir_t       dir_q, dir_d;
    logic       status_err_q, status_err_d;
    logic [6:0] sym, digit, hex0_q, hex0_d, hex1_q, hex1_d;

    // S2: decode from S1 and register the outputs
    always_comb begin
        valid        = $onehot(floor_s1_q);
        between      = (floor_s1_q == 3'b000) && moving_s1_q;
        cur          = floor_s1_q[0] ? 2'd1 : (floor_s1_q[1] ? 2'd2 : 2'd3);
        last_floor_d = last_floor_q;
        dir_d        = dir_q;
        status_err_d = !(valid || between);
        if (valid) begin
            last_floor_d = cur;
            if (cur > last_floor_q)      dir_d = UP;
            else if (cur < last_floor_q) dir_d = DOWN;
            else if (!moving_s1_q)       dir_d = IDLE;
        end

        digit = seg_digit(last_floor_d);
        if (sos_s1_q)            sym = SEG_E;
        else if (wt_s1_q)        sym = SEG_F;
        else if (status_err_d)   sym = SEG_DASH;
        else if (dir_d == UP)    sym = SEG_UP;
        else if (dir_d == DOWN)  sym = SEG_DOWN;
        else if (door_s1_q)      sym = SEG_D;
        else                     sym = SEG_BLANK;

        if (status_err_d)                         hex0_d = SEG_DASH ^ POL;
        else if ((sos_s1_q || wt_s1_q) && !phase) hex0_d = SEG_BLANK ^ POL;
        else                                      hex0_d = digit ^ POL;
        hex1_d = sym ^ POL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_floor_q <= 2'd1;
            dir_q        <= IDLE;
            status_err_q <= 1'b0;
            hex0_q       <= SEG_BLANK ^ POL;
            hex1_q       <= SEG_BLANK ^ POL;
        end else begin
            last_floor_q <= last_floor_d;
            dir_q        <= dir_d;
            status_err_q <= status_err_d;
            hex0_q       <= hex0_d;
            hex1_q       <= hex1_d;
        end
    end

    assign hex0       = hex0_q;
    assign hex1       = hex1_q;
    assign dir_up     = (dir_q == UP);
    assign dir_down   = (dir_q == DOWN);
    assign status_err = status_err_q;

`ifdef ELEV_CHIME_EN
    localparam int CHIME_CYC = CHIME_MS * (CLK_FREQ / 1000);
    localparam int CCW       = $clog2(CHIME_CYC + 1);

    logic [CCW-1:0] chime_cnt_q, chime_cnt_d;
    logic           moving_s2_q;

    // Arrival is a falling edge of the registered moving line at a valid floor
    always_comb begin
        if (sos_s1_q)                                       chime_cnt_d = '0;
        else if (moving_s2_q && !moving_s1_q && valid)      chime_cnt_d = CCW'(CHIME_CYC);
        else if (chime_cnt_q != '0)                         chime_cnt_d = chime_cnt_q - CCW'(1);
        else                                                chime_cnt_d = chime_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chime_cnt_q <= '0;
            moving_s2_q <= 1'b0;
        end else begin
            chime_cnt_q <= chime_cnt_d;
            moving_s2_q <= moving_s1_q;
        end
    end

    assign chime = (chime_cnt_q != '0);
`endif

endmodule

// File: tb/tb_elevator_status_display.sv
// Randomized and directed bench for elevator_status_display against a behavioural model.
`timescale 1ns/1ps
module tb_elevator_status_display;

    localparam int CLK_FREQ  = 10000;
    localparam int BLINK_HZ  = 625;
    localparam int CHIME_MS  = 1;
    localparam int HALF      = 8;
    localparam int CHIME_CYC = 10;

    localparam logic [6:0] A_1 = 7'b0000110, A_2 = 7'b1011011, A_3 = 7'b1001111;
    localparam logic [6:0] A_DASH = 7'b1000000, A_E = 7'b1111001, A_F = 7'b1110001;
    localparam logic [6:0] A_D = 7'b1011110, A_UP = 7'b0100011, A_DN = 7'b0011100;

    logic clk = 1'b0;
    logic rst_n, floor1, floor2, floor3, door, moving, sos_mode, weight;
    logic [6:0] hex0, hex1;
    logic dir_up, dir_down, status_err;
`ifdef ELEV_CHIME_EN
    logic chime;
`endif

    always #5 clk = ~clk;

    elevator_status_display #(
        .CLK_FREQ(CLK_FREQ), .BLINK_HZ(BLINK_HZ), .SEG_ACTIVE_LOW(1), .CHIME_MS(CHIME_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .floor1(floor1), .floor2(floor2), .floor3(floor3),
        .door(door), .moving(moving), .sos_mode(sos_mode), .weight_limit_exceeded(weight),
        .hex0(hex0), .hex1(hex1), .dir_up(dir_up), .dir_down(dir_down),
`ifdef ELEV_CHIME_EN
        .chime(chime),
`endif
        .status_err(status_err)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural reference: floor/direction rules applied to the inputs seen one edge earlier
    int m_last = 1, m_dir = 0, m_cyc = 0, m_chime = 0;
    bit m_err = 0, m_prev_mov = 0;
    logic [6:0] s1 = '0;
    logic [6:0] exp_hex0, exp_hex1;
    logic exp_up, exp_dn, exp_err, exp_chime;

    function automatic logic [6:0] digit_code(input int f);
        return (f == 1) ? A_1 : (f == 2) ? A_2 : A_3;
    endfunction

    always @(posedge clk) begin : model
        int nb, cur;
        bit mov, valid, phase;
        logic [6:0] sym, dg;
        if (!rst_n) begin
            m_last = 1; m_dir = 0; m_err = 0; m_cyc = 0; m_chime = 0; m_prev_mov = 0;
            exp_hex0 = 7'h7F; exp_hex1 = 7'h7F;
        end else begin
            nb = int'(s1[0]) + int'(s1[1]) + int'(s1[2]);
            cur = s1[0] ? 1 : (s1[1] ? 2 : 3);
            mov = s1[4];
            valid = (nb == 1);
            phase = ((m_cyc / HALF) % 2) == 1;
            m_cyc++;
            if (valid) begin
                if (cur > m_last) m_dir = 1;
                else if (cur < m_last) m_dir = 2;
                else if (!mov) m_dir = 0;
                m_last = cur;
            end
            m_err = !(valid || (nb == 0 && mov));
            if (s1[5]) m_chime = 0;
            else if (m_prev_mov && !mov && valid) m_chime = CHIME_CYC;
            else if (m_chime > 0) m_chime--;
            m_prev_mov = mov;
            if (s1[5]) sym = A_E;
            else if (s1[6]) sym = A_F;
            else if (m_err) sym = A_DASH;
            else if (m_dir == 1) sym = A_UP;
            else if (m_dir == 2) sym = A_DN;
            else if (s1[3]) sym = A_D;
            else sym = 7'h00;
            dg = digit_code(m_last);
            if (m_err) exp_hex0 = ~A_DASH;
            else if ((s1[5] || s1[6]) && !phase) exp_hex0 = 7'h7F;
            else exp_hex0 = ~dg;
            exp_hex1 = ~sym;
        end
        exp_up = (m_dir == 1);
        exp_dn = (m_dir == 2);
        exp_err = m_err;
        exp_chime = (m_chime > 0);
        s1 = {weight, sos_mode, moving, door, floor3, floor2, floor1};
    end

    wire [16:0] obs_v = {hex0, hex1, dir_up, dir_down, status_err};
    wire [16:0] exp_v = {exp_hex0, exp_hex1, exp_up, exp_dn, exp_err};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fl, input logic d, input logic m, input logic s, input logic w);
        {floor3, floor2, floor1} = fl;
        door = d; moving = m; sos_mode = s; weight = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(3'b001, 0, 0, 0, 0);
        tick(3);
        checks++;
        if ({hex0, hex1} !== 14'h3FFF) begin
            failures++;
            $display("FAIL reset_hex: got %h/%h want 7f/7f", hex0, hex1);
        end
        checks++;
        if ({dir_up, dir_down, status_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000", {dir_up, dir_down, status_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_door();
        drive(3'b001, 1, 0, 0, 0);
        tick(2);
        checks++;
        if ({hex0, hex1} !== {~A_1, ~A_D}) begin
            failures++;
            $display("FAIL door_hex: got %h/%h want %h/%h", hex0, hex1, ~A_1, ~A_D);
        end
        checks++;
        if ({dir_up, dir_down, status_err} !== 3'b000) begin
            failures++;
            $display("FAIL door_flags: got %b want 000", {dir_up, dir_down, status_err});
        end
    endtask

    task automatic test_travel();
        logic [2:0] fl [6] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b100};
        bit mv [6] = '{1, 1, 1, 1, 1, 0};
        int dg [6] = '{1, 1, 2, 2, 3, 3};
        bit up [6] = '{0, 0, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            drive(fl[i], 0, mv[i], 0, 0);
            for (int c = 0; c < 3; c++) begin
                tick(1);
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL travel_model step%0d: got %h want %h", i, obs_v, exp_v);
                end
            end
            checks++;
            if (hex0 !== ~digit_code(dg[i]) || dir_up !== up[i]) begin
                failures++;
                $display("FAIL travel_step%0d: got hex0=%h up=%b want hex0=%h up=%b",
                         i, hex0, dir_up, ~digit_code(dg[i]), up[i]);
            end
        end
    endtask

    task automatic test_err();
        drive(3'b101, 0, 0, 0, 0);
        tick(2);
        checks++;
        if ({status_err, hex0, hex1} !== {1'b1, ~A_DASH, ~A_DASH}) begin
            failures++;
            $display("FAIL err_set: got err=%b %h/%h want err=1 %h/%h", status_err, hex0, hex1, ~A_DASH, ~A_DASH);
        end
        drive(3'b100, 0, 0, 0, 0);
        tick(1);
        checks++;
        if (status_err !== 1'b1) begin
            failures++;
            $display("FAIL err_latency: got %b want 1", status_err);
        end
        tick(1);
        checks++;
        if ({status_err, hex0} !== {1'b0, ~A_3}) begin
            failures++;
            $display("FAIL err_clear: got err=%b hex0=%h want err=0 hex0=%h", status_err, hex0, ~A_3);
        end
    endtask

    task automatic test_blink();
        logic [6:0] prev;
        int last_t, ntr;
        drive(3'b010, 0, 0, 0, 0);
        tick(3);
        drive(3'b010, 0, 0, 1, 1);
        tick(2);
        checks++;
        if (hex1 !== ~A_E) begin
            failures++;
            $display("FAIL blink_sym: got %h want %h", hex1, ~A_E);
        end
        prev = hex0; last_t = -1; ntr = 0;
        for (int i = 0; i < 48; i++) begin
            tick(1);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL blink_model cyc%0d: got %h want %h", i, obs_v, exp_v);
            end
            if (i >= 10 && hex0 !== prev) begin
                if (last_t >= 0) begin
                    checks++;
                    if (i - last_t != HALF) begin
                        failures++;
                        $display("FAIL blink_period: got %0d want %0d", i - last_t, HALF);
                    end
                end
                last_t = i; ntr++;
            end
            prev = hex0;
        end
        checks++;
        if (ntr < 3) begin
            failures++;
            $display("FAIL blink_toggles: got %0d want >=3", ntr);
        end
    endtask

    task automatic test_reset_mid();
        drive(3'b100, 0, 0, 0, 0); tick(3);
        drive(3'b100, 0, 1, 0, 0); tick(2);
        drive(3'b000, 0, 1, 0, 0); tick(2);
        drive(3'b010, 0, 1, 0, 0); tick(3);
        checks++;
        if (dir_down !== 1'b1) begin
            failures++;
            $display("FAIL midrst_down: got %b want 1", dir_down);
        end
        drive(3'b000, 0, 1, 0, 0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checks++;
        if ({hex0, hex1, dir_up, dir_down} !== 16'hFFFC) begin
            failures++;
            $display("FAIL midrst_off: got %h want fffc", {hex0, hex1, dir_up, dir_down});
        end
        tick(1);
        checks++;
        if ({hex0, dir_down} !== {~A_1, 1'b0}) begin
            failures++;
            $display("FAIL midrst_floor: got hex0=%h dn=%b want %h/0", hex0, dir_down, ~A_1);
        end
    endtask

    task automatic test_random();
        logic [2:0] fl;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    fl = 3'b001;
                2:       fl = 3'b010;
                3:       fl = 3'b100;
                4:       fl = 3'b000;
                default: fl = 3'($urandom_range(0, 7));
            endcase
            drive(fl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 40) != 0);
            repeat ($urandom_range(1, 4)) begin
                tick(1);
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL random_model it%0d: got %h want %h", i, obs_v, exp_v);
                end
            end
        end
        rst_n = 1'b1;
    endtask

`ifdef ELEV_CHIME_EN
    task automatic test_chime();
        int hi;
        for (int pass = 0; pass < 2; pass++) begin
            drive(3'b100, 0, 1, pass == 1, 0); tick(3);
            drive(3'b100, 0, 0, pass == 1, 0);
            hi = 0;
            for (int i = 0; i < 30; i++) begin
                tick(1);
                if (chime === 1'b1) hi++;
                checks++;
                if (chime !== exp_chime) begin
                    failures++;
                    $display("FAIL chime_model p%0d cyc%0d: got %b want %b", pass, i, chime, exp_chime);
                end
            end
            checks++;
            if (hi != ((pass == 0) ? CHIME_CYC : 0)) begin
                failures++;
                $display("FAIL chime_len p%0d: got %0d want %0d", pass, hi, (pass == 0) ? CHIME_CYC : 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_door();
        test_travel();
        test_err();
        test_blink();
        test_reset_mid();
        test_random();
`ifdef ELEV_CHIME_EN
        test_chime();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
